// File: rtl/pomodoro_pkg.sv
// rtl/pomodoro_pkg.sv - shared state/phase encodings and constants for the Pomodoro sequencer
package pomodoro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WORK  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } phase_t;

    localparam int SEC_MAX = 59;

endpackage

// File: rtl/pomodoro_sequencer_if.sv
// rtl/pomodoro_sequencer_if.sv - control inputs and display/status outputs of the Pomodoro sequencer
interface pomodoro_sequencer_if;
    logic       tick;
    logic       swPlayPause;
    logic       bIncrementa5;
    logic       bDecrementa5;
    logic       bIncrementa1;
    logic       bDecrementa1;
    logic       bParar;
    logic [3:0] dezMin;
    logic [3:0] uniMin;
    logic [3:0] dezSeg;
    logic [3:0] uniSeg;
    logic [1:0] phase;
    logic [1:0] state;
    logic       alarm;
    logic [2:0] cycleCount;

    modport master (
        output tick, swPlayPause, bIncrementa5, bDecrementa5, bIncrementa1, bDecrementa1, bParar,
        input  dezMin, uniMin, dezSeg, uniSeg, phase, state, alarm, cycleCount
    );

    modport slave (
        input  tick, swPlayPause, bIncrementa5, bDecrementa5, bIncrementa1, bDecrementa1, bParar,
        output dezMin, uniMin, dezSeg, uniSeg, phase, state, alarm, cycleCount
    );
endinterface

// File: rtl/pomodoro_bin2bcd.sv
// rtl/pomodoro_bin2bcd.sv - combinational 0..99 binary to two-digit BCD split
module pomodoro_bin2bcd (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] units
);
    assign tens  = 4'(bin / 7'd10);
    assign units = 4'(bin % 7'd10);
endmodule

// File: rtl/pomodoro_sequencer.sv
// rtl/pomodoro_sequencer.sv - Pomodoro phase FSM and mm:ss countdown; long breaks enabled by POMODORO_LONG_BREAK_EN
module pomodoro_sequencer
    import pomodoro_pkg::*;
#(
    parameter int WORK_MIN        = 25,
    parameter int SHORT_MIN       = 5,
    parameter int LONG_MIN        = 15,
    parameter int CYCLES_PER_LONG = 4,
    parameter int MAX_MIN         = 99,
    parameter int ALARM_TICKS     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    pomodoro_sequencer_if.slave  bus
);

`ifdef POMODORO_LONG_BREAK_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    localparam logic [6:0] WORK7   = 7'(WORK_MIN);
    localparam logic [6:0] SHORT7  = 7'(SHORT_MIN);
    localparam logic [6:0] LONG7   = 7'(LONG_MIN);
    localparam logic [6:0] MAX7    = 7'(MAX_MIN);
    localparam logic [6:0] SEC7    = 7'(SEC_MAX);
    localparam logic [2:0] CYC3    = 3'(CYCLES_PER_LONG);
    localparam logic [7:0] AL_LAST = 8'(ALARM_TICKS - 1);

    state_t     st;
    phase_t     ph;
    logic [6:0] work_min, min_r, sec_r;
    logic [2:0] cyc;
    logic [7:0] alarm_cnt;
    logic       alarm_r;
    logic [4:0] btn_now, btn_q, rise;

    // Bit order {stop, inc5, dec5, inc1, dec1}; history resets to 1 so a held button is not a press.
    assign btn_now = {bus.bParar, bus.bIncrementa5, bus.bDecrementa5, bus.bIncrementa1, bus.bDecrementa1};
    assign rise    = btn_now & ~btn_q;

    logic [7:0] wm;
    logic [6:0] work_adj;
    always_comb begin
        wm       = {1'b0, work_min};
        work_adj = work_min;
        if (rise[3])      work_adj = (wm + 8'd5 > {1'b0, MAX7}) ? MAX7 : 7'(wm + 8'd5);
        else if (rise[2]) work_adj = (wm < 8'd6) ? 7'd1 : 7'(wm - 8'd5);
        else if (rise[1]) work_adj = (wm >= {1'b0, MAX7}) ? MAX7 : 7'(wm + 8'd1);
        else if (rise[0]) work_adj = (wm <= 8'd1) ? 7'd1 : 7'(wm - 8'd1);
    end

    logic [6:0] dn_min, dn_sec;
    logic       dn_zero;
    logic [2:0] cyc_inc;
    logic       go_long;
    always_comb begin
        dn_min = min_r;
        dn_sec = sec_r - 7'd1;
        if (sec_r == 7'd0) begin
            dn_min = min_r - 7'd1;
            dn_sec = SEC7;
        end
        dn_zero = (min_r == 7'd0) && (sec_r == 7'd1);
        cyc_inc = cyc + 3'd1;
        go_long = LONG_EN && (cyc_inc == CYC3);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= IDLE;
            ph        <= WORK;
            work_min  <= WORK7;
            min_r     <= WORK7;
            sec_r     <= 7'd0;
            cyc       <= 3'd0;
            alarm_cnt <= 8'd0;
            alarm_r   <= 1'b0;
            btn_q     <= 5'b11111;
        end else begin
            btn_q <= btn_now;
            case (st)
                IDLE: begin
                    work_min <= work_adj;
                    min_r    <= work_adj;
                    sec_r    <= 7'd0;
                    if (bus.swPlayPause) st <= RUN;
                end
                RUN: begin
                    if (!bus.swPlayPause) begin
                        st <= PAUSE;
                    end else if (bus.tick) begin
                        min_r <= dn_min;
                        sec_r <= dn_sec;
                        if (dn_zero) begin
                            st        <= ALARM;
                            alarm_r   <= 1'b1;
                            alarm_cnt <= 8'd0;
                        end
                    end
                end
                PAUSE: begin
                    if (rise[4]) begin
                        st    <= IDLE;
                        ph    <= WORK;
                        cyc   <= 3'd0;
                        min_r <= work_min;
                        sec_r <= 7'd0;
                    end else if (bus.swPlayPause) begin
                        st <= RUN;
                    end
                end
                ALARM: begin
                    if (bus.tick) begin
                        if (alarm_cnt >= AL_LAST) begin
                            alarm_cnt <= 8'd0;
                            alarm_r   <= 1'b0;
                            sec_r     <= 7'd0;
                            st        <= bus.swPlayPause ? RUN : PAUSE;
                            if (ph == WORK) begin
                                ph    <= go_long ? LONG : SHORT;
                                min_r <= go_long ? LONG7 : SHORT7;
                                cyc   <= (go_long || !LONG_EN) ? 3'd0 : cyc_inc;
                            end else begin
                                ph    <= WORK;
                                min_r <= work_min;
                            end
                        end else begin
                            alarm_cnt <= alarm_cnt + 8'd1;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.state      = st;
    assign bus.phase      = ph;
    assign bus.alarm      = alarm_r;
    assign bus.cycleCount = cyc;

    pomodoro_bin2bcd u_min_bcd (.bin(min_r), .tens(bus.dezMin), .units(bus.uniMin));
    pomodoro_bin2bcd u_sec_bcd (.bin(sec_r), .tens(bus.dezSeg), .units(bus.uniSeg));

endmodule

// File: tb/tb_pomodoro_sequencer.sv
// tb/tb_pomodoro_sequencer.sv - directed self-checking bench for pomodoro_sequencer
module tb_pomodoro_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt = 0;
    int   total = 0;

    pomodoro_sequencer_if bus ();

    pomodoro_sequencer #(
        .WORK_MIN(2), .SHORT_MIN(1), .LONG_MIN(3),
        .CYCLES_PER_LONG(2), .MAX_MIN(12), .ALARM_TICKS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

`ifdef POMODORO_LONG_BREAK_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    function automatic logic [15:0] digits();
        return {bus.dezMin, bus.uniMin, bus.dezSeg, bus.uniSeg};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(9);
            bus.tick = 1'b1;
            cyc(1);
            bus.tick = 1'b0;
        end
    endtask

    // m = {stop, inc5, dec5, inc1, dec1}
    task automatic press(input logic [4:0] m);
        {bus.bParar, bus.bIncrementa5, bus.bDecrementa5, bus.bIncrementa1, bus.bDecrementa1} = m;
        cyc(1);
        {bus.bParar, bus.bIncrementa5, bus.bDecrementa5, bus.bIncrementa1, bus.bDecrementa1} = 5'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc(2);
        total++; if (bus.state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", bus.state); else pass_cnt++;
        total++; if (bus.phase !== 2'd0) $display("FAIL reset_phase got=%0d exp=0", bus.phase); else pass_cnt++;
        total++; if (digits() !== 16'h0200) $display("FAIL reset_time got=%h exp=0200", digits()); else pass_cnt++;
        total++; if (bus.alarm !== 1'b0 || bus.cycleCount !== 3'd0)
            $display("FAIL reset_alarm_cc got=%b/%0d exp=0/0", bus.alarm, bus.cycleCount); else pass_cnt++;
        rst = 1'b1;
        cyc(1);
    endtask

    task automatic test_adjust();
        press(5'b01000); press(5'b01000); press(5'b00001);
        total++; if (digits() !== 16'h1100) $display("FAIL adj_11 got=%h exp=1100", digits()); else pass_cnt++;
        press(5'b00100); press(5'b00100); press(5'b00100);
        total++; if (digits() !== 16'h0100) $display("FAIL adj_min_sat got=%h exp=0100", digits()); else pass_cnt++;
        repeat (4) press(5'b01000);
        total++; if (digits() !== 16'h1200) $display("FAIL adj_max_sat got=%h exp=1200", digits()); else pass_cnt++;
        press(5'b01111);
        total++; if (digits() !== 16'h1200) $display("FAIL adj_priority got=%h exp=1200", digits()); else pass_cnt++;
        press(5'b00110);
        total++; if (digits() !== 16'h0700) $display("FAIL adj_prio_dec5 got=%h exp=0700", digits()); else pass_cnt++;
        press(5'b00100);
        total++; if (digits() !== 16'h0200) $display("FAIL adj_back got=%h exp=0200", digits()); else pass_cnt++;
    endtask

    task automatic test_run_pause();
        bus.swPlayPause = 1'b1;
        cyc(1);
        ticks(3);
        total++; if (digits() !== 16'h0157 || bus.state !== 2'd1)
            $display("FAIL run_3 got=%h/%0d exp=0157/1", digits(), bus.state); else pass_cnt++;
        bus.swPlayPause = 1'b0;
        cyc(1);
        ticks(5);
        total++; if (digits() !== 16'h0157 || bus.state !== 2'd2)
            $display("FAIL pause_hold got=%h/%0d exp=0157/2", digits(), bus.state); else pass_cnt++;
        press(5'b01000);
        total++; if (digits() !== 16'h0157) $display("FAIL pause_btn got=%h exp=0157", digits()); else pass_cnt++;
        bus.swPlayPause = 1'b1;
        cyc(1);
        ticks(1);
        total++; if (digits() !== 16'h0156 || bus.state !== 2'd1)
            $display("FAIL resume got=%h/%0d exp=0156/1", digits(), bus.state); else pass_cnt++;
    endtask

    task automatic test_alarm();
        bus.swPlayPause = 1'b0;
        cyc(1);
        press(5'b10000);
        total++; if (digits() !== 16'h0200 || bus.state !== 2'd0)
            $display("FAIL stop_idle got=%h/%0d exp=0200/0", digits(), bus.state); else pass_cnt++;
        bus.swPlayPause = 1'b1;
        cyc(1);
        ticks(119);
        total++; if (digits() !== 16'h0001 || bus.state !== 2'd1)
            $display("FAIL pre_alarm got=%h/%0d exp=0001/1", digits(), bus.state); else pass_cnt++;
        ticks(1);
        total++; if (digits() !== 16'h0000 || bus.state !== 2'd3 || bus.alarm !== 1'b1)
            $display("FAIL alarm_enter got=%h/%0d/%b exp=0000/3/1", digits(), bus.state, bus.alarm); else pass_cnt++;
        ticks(1);
        total++; if (bus.state !== 2'd3 || bus.alarm !== 1'b1)
            $display("FAIL alarm_hold got=%0d/%b exp=3/1", bus.state, bus.alarm); else pass_cnt++;
        ticks(1);
        total++; if (bus.phase !== 2'd1 || digits() !== 16'h0100 || bus.state !== 2'd1 || bus.alarm !== 1'b0)
            $display("FAIL to_short got=%0d/%h/%0d/%b exp=1/0100/1/0", bus.phase, digits(), bus.state, bus.alarm); else pass_cnt++;
        total++; if (bus.cycleCount !== (LONG_EN ? 3'd1 : 3'd0))
            $display("FAIL cc_after_work got=%0d exp=%0d", bus.cycleCount, LONG_EN ? 1 : 0); else pass_cnt++;
    endtask

    task automatic test_long_break();
        ticks(60);
        ticks(2);
        total++; if (bus.phase !== 2'd0 || digits() !== 16'h0200 || bus.state !== 2'd1)
            $display("FAIL to_work got=%0d/%h/%0d exp=0/0200/1", bus.phase, digits(), bus.state); else pass_cnt++;
        ticks(120);
        ticks(2);
        if (LONG_EN) begin
            total++; if (bus.phase !== 2'd2 || digits() !== 16'h0300 || bus.cycleCount !== 3'd0)
                $display("FAIL to_long got=%0d/%h/%0d exp=2/0300/0", bus.phase, digits(), bus.cycleCount); else pass_cnt++;
        end else begin
            total++; if (bus.phase !== 2'd1 || digits() !== 16'h0100 || bus.cycleCount !== 3'd0)
                $display("FAIL second_short got=%0d/%h/%0d exp=1/0100/0", bus.phase, digits(), bus.cycleCount); else pass_cnt++;
        end
    endtask

    task automatic test_stop_priority();
        bus.swPlayPause = 1'b0;
        cyc(1);
        total++; if (bus.state !== 2'd2) $display("FAIL pause_enter got=%0d exp=2", bus.state); else pass_cnt++;
        bus.bParar = 1'b1;
        bus.swPlayPause = 1'b1;
        cyc(1);
        total++; if (bus.state !== 2'd0 || digits() !== 16'h0200 || bus.phase !== 2'd0 || bus.cycleCount !== 3'd0)
            $display("FAIL stop_prio got=%0d/%h/%0d/%0d exp=0/0200/0/0", bus.state, digits(), bus.phase, bus.cycleCount); else pass_cnt++;
        bus.bParar = 1'b0;
        bus.swPlayPause = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset_mid_run();
        bus.swPlayPause = 1'b1;
        cyc(1);
        ticks(5);
        total++; if (digits() !== 16'h0155) $display("FAIL run_55 got=%h exp=0155", digits()); else pass_cnt++;
        #2;
        rst = 1'b0;
        #1;
        total++; if (bus.state !== 2'd0 || digits() !== 16'h0200 || bus.alarm !== 1'b0)
            $display("FAIL async_rst got=%0d/%h/%b exp=0/0200/0", bus.state, digits(), bus.alarm); else pass_cnt++;
        bus.swPlayPause = 1'b0;
        cyc(1);
    endtask

    task automatic test_held_button();
        bus.bIncrementa5 = 1'b1;
        cyc(1);
        rst = 1'b1;
        cyc(2);
        bus.bIncrementa5 = 1'b0;
        cyc(1);
        total++; if (digits() !== 16'h0200) $display("FAIL held_btn got=%h exp=0200", digits()); else pass_cnt++;
    endtask

    task automatic test_tick_pause_same_cycle();
        bus.swPlayPause = 1'b1;
        cyc(1);
        ticks(30);
        total++; if (digits() !== 16'h0130) $display("FAIL run_130 got=%h exp=0130", digits()); else pass_cnt++;
        cyc(9);
        bus.tick = 1'b1;
        bus.swPlayPause = 1'b0;
        cyc(1);
        bus.tick = 1'b0;
        total++; if (bus.state !== 2'd2 || digits() !== 16'h0130)
            $display("FAIL tick_drop got=%0d/%h exp=2/0130", bus.state, digits()); else pass_cnt++;
    endtask

    initial begin
        bus.tick = 1'b0;
        bus.swPlayPause = 1'b0;
        bus.bIncrementa5 = 1'b0;
        bus.bDecrementa5 = 1'b0;
        bus.bIncrementa1 = 1'b0;
        bus.bDecrementa1 = 1'b0;
        bus.bParar = 1'b0;
        test_reset();
        test_adjust();
        test_run_pause();
        test_alarm();
        test_long_break();
        test_stop_priority();
        test_reset_mid_run();
        test_held_button();
        test_tick_pause_same_cycle();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/pomodoro_sequencer.md
Name: pomodoro_sequencer

Overview:
Phase controller for the Pomodoro timer. It owns the mm:ss countdown and sequences WORK → SHORT/LONG break → WORK, advancing one second per 1 Hz tick pulse. It handles play/pause, the work-duration adjust buttons, and the end-of-phase alarm. Its BCD digit outputs feed the existing 7-segment decoders; its tick input comes from the existing timer divider.

Parameters:
WORK_MIN, 25, reset value of the configurable work duration in minutes (1..MAX_MIN)
SHORT_MIN, 5, short-break duration in minutes
LONG_MIN, 15, long-break duration in minutes
CYCLES_PER_LONG, 4, number of completed WORK phases per long break
MAX_MIN, 99, upper saturation limit for the work duration
ALARM_TICKS, 3, number of ticks spent in ALARM

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
tick  in  1  one-clk-wide pulse per second
swPlayPause  in  1  level switch; 1 = run, 0 = pause
bIncrementa5  in  1  button, level; in IDLE adds 5 to the work duration
bDecrementa5  in  1  button, level; in IDLE subtracts 5 from the work duration
bIncrementa1  in  1  button, level; in IDLE adds 1 to the work duration
bDecrementa1  in  1  button, level; in IDLE subtracts 1 from the work duration
bParar  in  1  button, level; in PAUSE returns to IDLE
dezMin, uniMin, dezSeg, uniSeg  out  4 each  BCD digits of the remaining time
phase  out  2  0 = WORK, 1 = SHORT, 2 = LONG
state  out  2  0 = IDLE, 1 = RUN, 2 = PAUSE, 3 = ALARM
alarm  out  1  high while state = ALARM
cycleCount  out  3  completed WORK phases modulo CYCLES_PER_LONG

Behaviour:
- Reset (rst=0, async, takes effect at any time including mid-phase):
  - state=IDLE, phase=WORK, workMin=WORK_MIN, remaining time = WORK_MIN:00, cycleCount=0, alarm=0, alarm counter=0.
  - Button history registers reset to 1, so a button held through reset release is not counted as a press.
- All outputs are registered. The BCD digits are the combinational split of the registered min/sec values, so any change is visible one clk after the causing edge.
- Buttons are rising-edge detected: one action per press.
  - Actions apply only in IDLE; presses in other states are ignored.
  - Simultaneous presses: priority inc5 > dec5 > inc1 > dec1; only one action per cycle.
  - Increments saturate at MAX_MIN; decrements saturate at 1.
  - In IDLE the remaining time always tracks workMin:00.
- State transitions:
  - IDLE → RUN when swPlayPause=1.
  - RUN → PAUSE when swPlayPause=0.
  - PAUSE → RUN when swPlayPause=1.
  - PAUSE → IDLE on a bParar rising edge. This reloads workMin:00, sets phase=WORK and cycleCount=0. bParar has priority over swPlayPause in the same cycle.
- Countdown, when state=RUN and tick=1 and swPlayPause=1:
  - sec>0: decrement sec.
  - sec=0 and min>0: decrement min, set sec=59.
  - A tick in the same cycle as the RUN→PAUSE transition is dropped.
- When a decrement produces 00:00, the next state is ALARM on that same edge. There is no extra tick at 00:00.
- ALARM:
  - Counts ALARM_TICKS ticks; tick is honoured regardless of swPlayPause. bParar is ignored.
  - On the final tick, advance the phase and load its duration with seconds = 00.
  - Then go to RUN if swPlayPause=1, otherwise to PAUSE.
- Phase advance:
  - From WORK: cycleCount increments. If it reaches CYCLES_PER_LONG, next phase = LONG and cycleCount=0; otherwise next phase = SHORT.
  - From SHORT or LONG: next phase = WORK.
- A tick arriving in IDLE or PAUSE has no effect.

Optional Feature:
POMODORO_LONG_BREAK_EN.
- Defined: long-break scheduling exactly as described above.
- Undefined: every break is SHORT, cycleCount is held at 0, and LONG_MIN is unused. phase never equals 2.

Decomposition:
- Package pomodoro_pkg holds:
  - state_t enum (IDLE, RUN, PAUSE, ALARM).
  - phase_t enum (WORK, SHORT, LONG).
  - SEC_MAX = 59.
- Sub-module pomodoro_bin2bcd: 7-bit binary (0..99) → tens/units BCD, combinational, instanced twice (minutes, seconds).
- Edge detection and the FSM stay in the top module.

Test Plan:
Bench parameters: WORK_MIN=2, SHORT_MIN=1, LONG_MIN=3, CYCLES_PER_LONG=2, ALARM_TICKS=2; tick generated every 10 clk.
1. Reset, then press inc5, inc5, dec1 in IDLE → digits 1,1,0,0 (11:00). Press dec5 three times → 01:00. Press inc5 repeatedly with MAX_MIN=12 → saturates at 12:00.
2. From 02:00, swPlayPause=1 with 3 ticks → 01:57. Set switch 0, apply 5 ticks → still 01:57, state=PAUSE. Set switch 1 → resumes.
3. Run 120 ticks from 02:00 → state=ALARM, alarm=1 on the edge reaching 00:00. After 2 more ticks → phase=SHORT, time 01:00, state=RUN, cycleCount=1.
4. Complete WORK, SHORT, WORK → phase=LONG, 03:00, cycleCount=0. Without POMODORO_LONG_BREAK_EN → phase=SHORT, 01:00.
5. In PAUSE, press bParar together with swPlayPause=1 → IDLE, 02:00, phase=WORK. Assert rst mid-RUN → immediately IDLE, 02:00, alarm=0.
6. Hold inc5 across rst release → no increment. Apply tick and switch-to-0 in the same cycle at 01:30 → PAUSE with 01:30 unchanged.
